// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer.
// State encoding, lock-loss counter width, width helpers.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int LOSS_W = 8;

  function automatic int max3(input int a,
                              input int b,
                              input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Never returns zero, so tiny parameters still give a legal vector.
  function automatic int width_of(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit.
// Ports: clk, rst_n (async low), d (async in), q (synchronized).
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / recovery sequencer with lock timeout and retry limit.
// Ports: refclk, rst_n, pll_locked, sw_reset_req -> pll_areset,
// sys_reset_n, pll_fail, state, lock_loss_count.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES        = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  output logic              pll_areset,
  output logic              sys_reset_n,
  output logic              pll_fail,
  output logic [2:0]        state,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int CNT_W = width_of(max3(RESET_CYCLES,
                                       LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES));
  localparam int RTY_W = width_of(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             loss_inc;
  logic             locked_s;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  always_comb begin
    st_d     = st_q;
    retry_d  = retry_q;
    loss_inc = 1'b0;
    if (sw_reset_req) begin
      st_d    = ST_RESET;
      retry_d = '0;
    end else begin
      unique case (st_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) st_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            st_d = ST_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_q + 1'b1;
            st_d    = (retry_d == RTY_MAX) ? ST_FAIL : ST_RESET;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            st_d = ST_WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            st_d    = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            st_d     = ST_RESET;
            loss_inc = 1'b1;
          end
        end
        ST_FAIL: st_d = ST_FAIL;
        default: st_d = ST_RESET;
      endcase
    end
  end

  // Counter restarts on any state change or software restart;
  // it is frozen in RUN and FAIL where nothing times out.
  always_comb begin
    cnt_d = cnt_q;
    if (sw_reset_req || (st_d != st_q))
      cnt_d = '0;
    else if (st_q != ST_RUN && st_q != ST_FAIL)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q            <= ST_RESET;
      cnt_q           <= '0;
      retry_q         <= '0;
      pll_areset      <= 1'b1;
      sys_reset_n     <= 1'b0;
      pll_fail        <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_areset  <= (st_d == ST_RESET) || (st_d == ST_FAIL);
      sys_reset_n <= (st_d == ST_RUN);
      pll_fail    <= (st_d == ST_FAIL);
      if (loss_inc && lock_loss_count != LOSS_MAX)
        lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer.
// Small parameters: 4/20/8 cycles, 2 retries, 2 sync stages.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_areset;
  logic       sys_reset_n;
  logic       pll_fail;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RESET_CYCLES       (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .sw_reset_req   (sw_reset_req),
    .pll_areset     (pll_areset),
    .sys_reset_n    (sys_reset_n),
    .pll_fail       (pll_fail),
    .state          (state),
    .lock_loss_count(lock_loss_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_st;
    int exp_loss;

    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;

    // reset state
    step(3);
    chk("rst_state", state, 0);
    chk("rst_areset", pll_areset, 1);
    chk("rst_sysn", sys_reset_n, 0);
    chk("rst_fail", pll_fail, 0);
    chk("rst_loss", lock_loss_count, 0);

    // power-up
    @(negedge refclk);
    rst_n = 1'b1;
    step(3);
    chk("pu_areset_e3", pll_areset, 1);
    step(1);
    chk("pu_areset_e4", pll_areset, 0);
    chk("pu_state_e4", state, 1);
    step(6);
    pll_locked = 1'b1;
    step(2);
    chk("pu_state_e12", state, 1);
    step(1);
    chk("pu_state_e13", state, 2);
    step(7);
    chk("pu_sysn_e20", sys_reset_n, 0);
    step(1);
    chk("pu_sysn_e21", sys_reset_n, 1);
    chk("pu_state_e21", state, 3);

    // single lock loss
    pll_locked = 1'b0;
    step(2);
    chk("loss_sysn_e2", sys_reset_n, 1);
    step(1);
    chk("loss_sysn_e3", sys_reset_n, 0);
    chk("loss_state_e3", state, 0);
    chk("loss_areset_e3", pll_areset, 1);
    chk("loss_cnt1", lock_loss_count, 1);
    step(3);
    chk("loss_areset_e6", pll_areset, 1);
    step(1);
    chk("loss_areset_e7", pll_areset, 0);
    chk("loss_state_e7", state, 1);

    // unstable lock: high 5, low 2, high
    pll_locked = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step(1);
      exp_st = (i < 3) ? 1 : (i <= 7) ? 2 :
               (i <= 9) ? 1 : (i <= 17) ? 2 : 3;
      chk("unst_state", state, exp_st);
      chk("unst_areset", pll_areset, 0);
      chk("unst_sysn", sys_reset_n, (i == 18) ? 1 : 0);
      if (i == 5) pll_locked = 1'b0;
      if (i == 7) pll_locked = 1'b1;
    end

    // repeated lock loss, counter saturation
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b0;
      step(2);
      chk("rep_sysn_e2", sys_reset_n, 1);
      step(1);
      chk("rep_sysn_e3", sys_reset_n, 0);
      chk("rep_state_e3", state, 0);
      chk("rep_areset_e3", pll_areset, 1);
      exp_loss = (k + 1 > 255) ? 255 : k + 1;
      chk("rep_loss", lock_loss_count, exp_loss);
      pll_locked = 1'b1;
      step(13);
      chk("rep_run", state, 3);
    end

    // lock timeout into FAIL
    pll_locked = 1'b0;
    step(3);
    chk("to_state_e3", state, 0);
    chk("to_loss_sat", lock_loss_count, 255);
    step(3);
    chk("to_areset_e6", pll_areset, 1);
    step(1);
    chk("to_areset_e7", pll_areset, 0);
    step(19);
    chk("to_state_e26", state, 1);
    chk("to_areset_e26", pll_areset, 0);
    step(1);
    chk("to_state_e27", state, 0);
    chk("to_areset_e27", pll_areset, 1);
    step(3);
    chk("to_areset_e30", pll_areset, 1);
    step(1);
    chk("to_areset_e31", pll_areset, 0);
    step(19);
    chk("to_state_e50", state, 1);
    step(1);
    chk("to_state_e51", state, 4);
    chk("to_fail_e51", pll_fail, 1);
    chk("to_areset_e51", pll_areset, 1);
    chk("to_sysn_e51", sys_reset_n, 0);
    step(5);
    chk("to_state_hold", state, 4);
    chk("to_fail_hold", pll_fail, 1);

    // recovery from FAIL
    sw_reset_req = 1'b1;
    pll_locked   = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    chk("rec_state", state, 0);
    chk("rec_fail", pll_fail, 0);
    chk("rec_areset", pll_areset, 1);
    step(12);
    chk("rec_state_12", state, 2);
    chk("rec_sysn_12", sys_reset_n, 0);
    step(1);
    chk("rec_state_13", state, 3);
    chk("rec_sysn_13", sys_reset_n, 1);

    // sw_reset_req on the edge of the final timeout
    pll_locked = 1'b0;
    step(3);
    chk("sim_state_e3", state, 0);
    step(47);
    chk("sim_state_e50", state, 1);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    chk("sim_state_e51", state, 0);
    chk("sim_fail_e51", pll_fail, 0);
    chk("sim_areset_e51", pll_areset, 1);
    step(23);
    chk("sim_state_e74", state, 1);
    step(1);
    chk("sim_state_e75", state, 0);
    chk("sim_fail_e75", pll_fail, 0);
    step(23);
    chk("sim_state_e98", state, 1);
    step(1);
    chk("sim_state_e99", state, 4);
    chk("sim_fail_e99", pll_fail, 1);

    // async reset in the middle of STABLE
    sw_reset_req = 1'b1;
    pll_locked   = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    chk("mid_state_s0", state, 0);
    step(7);
    chk("mid_state_s7", state, 2);
    chk("mid_areset_s7", pll_areset, 0);
    chk("mid_loss_s7", lock_loss_count, 255);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_areset", pll_areset, 1);
    chk("mid_rst_sysn", sys_reset_n, 0);
    chk("mid_rst_fail", pll_fail, 0);
    chk("mid_rst_loss", lock_loss_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controls power-up and recovery of the system PLL in the DE10-Lite computer, clocked from the free-running 50 MHz board reference.
- Holds the PLL in `areset` for a fixed interval, then waits for `locked` with a timeout.
- Requires lock to stay continuously stable before releasing the system reset.
- On loss of lock, re-resets the PLL; after repeated lock timeouts it parks in a failure state until software requests a restart.

## Interface
- `RESET_CYCLES`, 10: refclk cycles `pll_areset` is held high on each PLL reset.
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum cycles in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before reset release.
- `MAX_RETRIES`, 3: consecutive lock timeouts tolerated before FAIL.
- `SYNC_STAGES`, 2: flop depth of the `pll_locked` synchronizer (≥2).
- `refclk`  in  1  board reference clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  raw PLL lock output; asynchronous to `refclk`.
- `sw_reset_req`  in  1  single-cycle request to restart the sequence from RESET.
- `pll_areset`  out  1  PLL reset, active high.
- `sys_reset_n`  out  1  system reset release, active low, registered.
- `pll_fail`  out  1  high in FAIL.
- `state`  out  3  current FSM encoding.
- `lock_loss_count`  out  8  saturating count of lock losses seen in RUN.

## Operation
- **Lock synchronizer:** `pll_locked` passes through `SYNC_STAGES` flops to give `locked_s`. All decisions use `locked_s` only.
- **FSM states:** RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. One shared cycle counter `cnt`, cleared on every state change.
- **RESET:**
  - `pll_areset`=1.
  - When `cnt`=RESET_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `pll_areset`=0.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt`=LOCK_TIMEOUT_CYCLES-1: increment `retry`. If the new `retry` equals MAX_RETRIES, go to FAIL; otherwise go to RESET.
- **STABLE:**
  - If `locked_s`=0, go to WAIT_LOCK (no PLL reset).
  - If `cnt`=LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to RUN and clear `retry`.
- **RUN:**
  - `sys_reset_n`=1.
  - If `locked_s`=0, go to RESET and increment `lock_loss_count`, saturating at 255.
- **FAIL:**
  - `pll_areset`=1, `sys_reset_n`=0, `pll_fail`=1.
  - Exits only on `sw_reset_req`.
- **Software restart:** `sw_reset_req`=1 in any state forces RESET and clears `cnt`, `retry` and `pll_fail`. It takes priority over every other transition in the same cycle. `lock_loss_count` is not cleared.
- **Output decode:** outputs are registered from the next-state decode, so each output changes on the same edge as `state`.
- **Widths:** `cnt` uses $clog2(max(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)); `retry` uses $clog2(MAX_RETRIES+1).

## Timing
- **During `rst_n`=0 (asynchronous):**
  - state=RESET, `cnt`=0, `retry`=0.
  - `pll_areset`=1, `sys_reset_n`=0, `pll_fail`=0, `lock_loss_count`=0.
  - Synchronizer flops = 0.
- **PLL reset pulse:** after `rst_n` rises, `pll_areset` falls on the RESET_CYCLES-th `refclk` edge.
- **Lock latency:** a raw `pll_locked` rise is visible on `locked_s` after SYNC_STAGES edges. STABLE is entered one edge later. `sys_reset_n` rises LOCK_STABLE_CYCLES edges after STABLE is entered.
- **Lock loss:** a drop in RUN asserts `pll_areset` and deasserts `sys_reset_n` SYNC_STAGES+1 edges after the raw fall.
- **Glitches:** a lock glitch shorter than one `refclk` period may be missed. This is acceptable; the PLL re-asserts `locked` only after relock.
- **Reset mid-operation:** `rst_n` asserted in any state returns every output to its reset value immediately.

## Structure
- `pll_seq_pkg` holds the state encoding localparams and the `lock_loss_count` width.
- Sub-module `bit_synchronizer` (parameter STAGES; ports `clk`, `rst_n`, `d`, `q`) is reused for any asynchronous single-bit input.
- The FSM, counters and output registers live in `pll_reset_sequencer`.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- **Power-up:** release `rst_n`; raise `pll_locked` at edge 10 → `pll_areset` falls at edge 4; `sys_reset_n` rises at edge 10+2+1+8=21; state=3.
- **Unstable lock:** `pll_locked` high 5 cycles, low 2 cycles, then high → FSM returns to WAIT_LOCK; `sys_reset_n` stays 0 until 8 consecutive stable cycles; `pll_areset` never reasserts.
- **Lock timeout:** hold `pll_locked`=0 → two PLL reset pulses of 4 cycles each, separated by 20 cycles in WAIT_LOCK; after the second timeout state=4, `pll_fail`=1, `pll_areset`=1.
- **Recovery from FAIL:** pulse `sw_reset_req` while in FAIL → next edge state=0, `pll_fail`=0; with lock present the sequence reaches RUN.
- **Lock loss in RUN:** drop `pll_locked` once per RUN, repeated 300 times → each drop gives `sys_reset_n`=0 after 3 edges; `lock_loss_count` saturates at 255.
- **Simultaneous events:** `sw_reset_req` on the same edge as a WAIT_LOCK timeout → state=RESET, `retry`=0, no FAIL; `rst_n` pulsed mid-STABLE → all outputs return to reset values asynchronously.
